hvac_zone_scheduler: RTL and testbench

//  Shares one heating/cooling plant between NUM_ZONES thermostat zones.
//  - Derives heat/cool demand per zone from its 5-bit temperature.
//  - Grants the plant to one zone at a time, round-robin.
//  - Enforces a minimum run time and an all-off changeover gap.
//  - Sits above the single-zone thermostat and drives the heating/cooling outputs on the top level.

---
 rtl/hvac_zone_scheduler_if.sv | 33 +++
 rtl/hvac_zone_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_hvac_zone_scheduler.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/hvac_zone_scheduler_if.sv
// ---------------------------------------------------------------------------
// hvac_zone_scheduler_if
// Bundles the zone-facing inputs and plant-facing outputs of the HVAC zone
// scheduler.
//   temps    : 5 bits per zone, zone i at temps[5*i +: 5], unsigned
//   zone_en  : per-zone enable; a disabled zone never requests the plant
//   heating  : plant heating on (registered)
//   cooling  : plant cooling on (registered)
//   zone_sel : one-hot granted zone, 0 when no zone holds the plant
//   busy     : high while a grant is running or during changeover
// Modports: master drives temps/zone_en (environment side),
//           slave drives the plant outputs (scheduler side).
// ---------------------------------------------------------------------------
interface hvac_zone_scheduler_if #(
    parameter int NUM_ZONES = 4
);
    logic [5*NUM_ZONES-1:0] temps;
    logic [NUM_ZONES-1:0]   zone_en;
    logic                   heating;
    logic                   cooling;
    logic [NUM_ZONES-1:0]   zone_sel;
    logic                   busy;

    modport master (
        output temps, zone_en,
        input  heating, cooling, zone_sel, busy
    );

    modport slave (
        input  temps, zone_en,
        output heating, cooling, zone_sel, busy
    );
endinterface

// File: rtl/hvac_zone_scheduler.sv
// ---------------------------------------------------------------------------
// hvac_zone_scheduler
// Shares one heating/cooling plant between NUM_ZONES thermostat zones.
// Each zone's demand is derived from its temperature; the plant is granted to
// one zone at a time in round-robin order, held for at least MIN_RUN cycles,
// and followed by an all-off changeover gap of CHANGEOVER cycles.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : hvac_zone_scheduler_if.slave (temps, zone_en in;
//            heating, cooling, zone_sel, busy out)
//
// Optional feature macro: HVAC_SCHED_PREEMPT_EN
//   When defined, a grant that has run for MAX_RUN cycles is released as soon
//   as any other zone has demand. When undefined there is no MAX_RUN logic.
// ---------------------------------------------------------------------------
module hvac_zone_scheduler #(
    parameter int NUM_ZONES  = 4,
    parameter int MIN_RUN    = 8,
    parameter int CHANGEOVER = 4,
    parameter int MAX_RUN    = 32,
    parameter int HEAT_ON    = 18,
    parameter int HEAT_OFF   = 20,
    parameter int COOL_ON    = 22,
    parameter int COOL_OFF   = 20
) (
    input  logic                   clk,
    input  logic                   rst_n,
    hvac_zone_scheduler_if.slave   bus
);

    localparam int PTR_W = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1;

`ifdef HVAC_SCHED_PREEMPT_EN
    localparam int CNT_MAX_A = (MAX_RUN > MIN_RUN) ? MAX_RUN : MIN_RUN;
`else
    localparam int CNT_MAX_A = MIN_RUN;
`endif
    localparam int CNT_MAX = (CNT_MAX_A > CHANGEOVER) ? CNT_MAX_A : CHANGEOVER;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [4:0] HEAT_ON_T  = 5'(HEAT_ON);
    localparam logic [4:0] HEAT_OFF_T = 5'(HEAT_OFF);
    localparam logic [4:0] COOL_ON_T  = 5'(COOL_ON);
    localparam logic [4:0] COOL_OFF_T = 5'(COOL_OFF);

    localparam logic [CNT_W-1:0] MIN_RUN_C    = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0] CHANGEOVER_C = CNT_W'(CHANGEOVER);
`ifdef HVAC_SCHED_PREEMPT_EN
    localparam logic [CNT_W-1:0] MAX_RUN_C    = CNT_W'(MAX_RUN);
`endif

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_RUN_HEAT   = 2'd1;
    localparam logic [1:0] ST_RUN_COOL   = 2'd2;
    localparam logic [1:0] ST_CHANGEOVER = 2'd3;

    logic [1:0]           state_q,    state_d;
    logic [CNT_W-1:0]     run_cnt_q,  run_cnt_d;
    logic [PTR_W-1:0]     rr_ptr_q,   rr_ptr_d;
    logic                 heating_q,  heating_d;
    logic                 cooling_q,  cooling_d;
    logic [NUM_ZONES-1:0] zone_sel_q, zone_sel_d;
    logic                 busy_q,     busy_d;

    logic [NUM_ZONES-1:0] heat_req;
    logic [NUM_ZONES-1:0] cool_req;
    logic [4:0]           zone_temp;
    logic [4:0]           gnt_temp;
    logic                 gnt_en;
    logic                 satisfied;
    logic                 release_grant;
    logic                 found;
    logic [PTR_W-1:0]     cand_ptr;
    logic [PTR_W-1:0]     sel_ptr;
`ifdef HVAC_SCHED_PREEMPT_EN
    logic                 preempt;
`endif

    // Per-zone demand; HEAT_ON < COOL_ON keeps the two requests exclusive.
    always_comb begin
        heat_req  = '0;
        cool_req  = '0;
        zone_temp = '0;
        for (int unsigned i = 0; i < NUM_ZONES; i++) begin
            zone_temp   = bus.temps[5*i +: 5];
            heat_req[i] = bus.zone_en[i] && (zone_temp <= HEAT_ON_T);
            cool_req[i] = bus.zone_en[i] && (zone_temp >= COOL_ON_T);
        end
    end

    // rr_ptr doubles as the index of the granted zone while running.
    assign gnt_temp = bus.temps[5*int'(rr_ptr_q) +: 5];
    assign gnt_en   = bus.zone_en[rr_ptr_q];

    always_comb begin
        state_d       = state_q;
        run_cnt_d     = run_cnt_q;
        rr_ptr_d      = rr_ptr_q;
        heating_d     = heating_q;
        cooling_d     = cooling_q;
        zone_sel_d    = zone_sel_q;
        busy_d        = busy_q;
        satisfied     = 1'b0;
        release_grant = 1'b0;
        found         = 1'b0;
        cand_ptr      = '0;
        sel_ptr       = '0;
`ifdef HVAC_SCHED_PREEMPT_EN
        preempt       = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                // Search rr_ptr+1 .. rr_ptr cyclically; first requester wins.
                for (int unsigned k = 1; k <= NUM_ZONES; k++) begin
                    cand_ptr = PTR_W'((int'(rr_ptr_q) + k) % NUM_ZONES);
                    if (!found && (heat_req[cand_ptr] || cool_req[cand_ptr])) begin
                        found   = 1'b1;
                        sel_ptr = cand_ptr;
                    end
                end
                if (found) begin
                    state_d             = heat_req[sel_ptr] ? ST_RUN_HEAT : ST_RUN_COOL;
                    heating_d           = heat_req[sel_ptr];
                    cooling_d           = ~heat_req[sel_ptr];
                    zone_sel_d          = '0;
                    zone_sel_d[sel_ptr] = 1'b1;
                    rr_ptr_d            = sel_ptr;
                    run_cnt_d           = CNT_W'(1);
                    busy_d              = 1'b1;
                end
            end

            ST_RUN_HEAT, ST_RUN_COOL: begin
                if (run_cnt_q != '1) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
                satisfied = (state_q == ST_RUN_HEAT) ? (gnt_temp >= HEAT_OFF_T)
                                                     : (gnt_temp <= COOL_OFF_T);
`ifdef HVAC_SCHED_PREEMPT_EN
                preempt = (run_cnt_q >= MAX_RUN_C) &&
                          (|((heat_req | cool_req) & ~zone_sel_q));
                release_grant = !gnt_en || ((run_cnt_q >= MIN_RUN_C) && satisfied) || preempt;
`else
                release_grant = !gnt_en || ((run_cnt_q >= MIN_RUN_C) && satisfied);
`endif
                if (release_grant) begin
                    state_d    = ST_CHANGEOVER;
                    heating_d  = 1'b0;
                    cooling_d  = 1'b0;
                    zone_sel_d = '0;
                    run_cnt_d  = CNT_W'(1);
                    busy_d     = 1'b1;
                end
            end

            default: begin
                // Changeover: run_cnt counts 1..CHANGEOVER with busy held high.
                if (run_cnt_q >= CHANGEOVER_C) begin
                    state_d   = ST_IDLE;
                    run_cnt_d = '0;
                    busy_d    = 1'b0;
                end else begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            run_cnt_q  <= '0;
            rr_ptr_q   <= PTR_W'(NUM_ZONES - 1);
            heating_q  <= 1'b0;
            cooling_q  <= 1'b0;
            zone_sel_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_cnt_q  <= run_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            heating_q  <= heating_d;
            cooling_q  <= cooling_d;
            zone_sel_q <= zone_sel_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.heating  = heating_q;
    assign bus.cooling  = cooling_q;
    assign bus.zone_sel = zone_sel_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hvac_zone_scheduler
// Directed self-checking bench for hvac_zone_scheduler with default
// parameters (4 zones, MIN_RUN=8, CHANGEOVER=4, MAX_RUN=32). Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_hvac_zone_scheduler;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hvac_zone_scheduler_if #(.NUM_ZONES(4)) bus ();

    hvac_zone_scheduler #(
        .NUM_ZONES (4),
        .MIN_RUN   (8),
        .CHANGEOVER(4),
        .MAX_RUN   (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int unsigned checks = 0;
    int unsigned passed = 0;

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_temp(input int unsigned z, input logic [4:0] v);
        bus.temps[5*z +: 5] = v;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_out(input string tag, input logic h, input logic c,
                             input logic [3:0] sel, input logic b);
        check({tag, ".heating"},  8'(bus.heating),  8'(h));
        check({tag, ".cooling"},  8'(bus.cooling),  8'(c));
        check({tag, ".zone_sel"}, 8'(bus.zone_sel), 8'(sel));
        check({tag, ".busy"},     8'(bus.busy),     8'(b));
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.zone_en = 4'b1111;
        bus.temps   = {5'd20, 5'd20, 5'd20, 5'd20};
        tick(2);
        check_out("reset", 1'b0, 1'b0, 4'b0000, 1'b0);
        rst_n = 1'b1;

        // Hysteresis band: 19 and 21 give no demand.
        set_temp(1, 5'd19);
        tick(3);
        check_out("band19", 1'b0, 1'b0, 4'b0000, 1'b0);
        set_temp(1, 5'd21);
        tick(3);
        check_out("band21", 1'b0, 1'b0, 4'b0000, 1'b0);
        set_temp(1, 5'd20);

        // Heat grant one edge after demand.
        set_temp(0, 5'd15);
        tick(1);
        check_out("grant0", 1'b1, 1'b0, 4'b0001, 1'b1);

        // Satisfied at run cycle 3: held until run_cnt=8.
        tick(2);
        set_temp(0, 5'd20);
        tick(5);
        check_out("minrun_last", 1'b1, 1'b0, 4'b0001, 1'b1);
        tick(1);
        check_out("release", 1'b0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("gap.heating", 8'(bus.heating), 8'd0);
        end
        check("gap_end.busy", 8'(bus.busy), 8'd0);

        // Enable drop releases immediately.
        set_temp(0, 5'd15);
        tick(1);
        check_out("grant_en", 1'b1, 1'b0, 4'b0001, 1'b1);
        tick(2);
        bus.zone_en = 4'b1110;
        tick(1);
        check_out("en_drop", 1'b0, 1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("co.busy", 8'(bus.busy), 8'd1);
        end
        tick(1);
        check("co_end.busy", 8'(bus.busy), 8'd0);
        bus.zone_en = 4'b1111;
        set_temp(0, 5'd20);

        // Two requesters from reset: zone0 heat first, then zone2 cool.
        rst_n = 1'b0;
        set_temp(0, 5'd15);
        set_temp(2, 5'd25);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_out("rr_first", 1'b1, 1'b0, 4'b0001, 1'b1);
        set_temp(0, 5'd20);
        tick(7);
        check("rr_hold.heating", 8'(bus.heating), 8'd1);
        tick(1);
        check_out("rr_release", 1'b0, 1'b0, 4'b0000, 1'b1);
        tick(3);
        check("rr_co4.busy", 8'(bus.busy), 8'd1);
        tick(1);
        check_out("rr_idle", 1'b0, 1'b0, 4'b0000, 1'b0);
        tick(1);
        check_out("rr_second", 1'b0, 1'b1, 4'b0100, 1'b1);

        // Long heat demand with a competing cool demand.
        rst_n = 1'b0;
        bus.temps = {5'd20, 5'd20, 5'd25, 5'd10};
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check_out("long_grant", 1'b1, 1'b0, 4'b0001, 1'b1);
`ifdef HVAC_SCHED_PREEMPT_EN
        tick(31);
        check_out("preempt_last", 1'b1, 1'b0, 4'b0001, 1'b1);
        tick(1);
        check_out("preempt_rel", 1'b0, 1'b0, 4'b0000, 1'b1);
        tick(5);
        check_out("preempt_next", 1'b0, 1'b1, 4'b0010, 1'b1);
`else
        tick(40);
        check_out("no_preempt", 1'b1, 1'b0, 4'b0001, 1'b1);
`endif
        // Asynchronous reset mid-run, between clock edges.
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b0, 4'b0000, 1'b0);
        tick(1);
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
